// File: rtl/gf_inv_serial.sv
// Sequential GF(2^M) inverter: a^-1 = a^(2^M-2) via a square/multiply chain on one bit-serial multiplier.
// Optional zero-operand flag output enabled by defining GF_INV_ZERO_FLAG_EN.
module gf_inv_serial #(
    parameter int         M    = 16,
    parameter logic [M:0] POLY = 17'h1002B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   dbg_state_o,
    output logic [M-1:0] out_inv
`ifdef GF_INV_ZERO_FLAG_EN
    ,
    output logic         out_zero
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // out_valid/out_inv stay stable until accepted, in_valid is ignored unless in_ready.
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    localparam logic [5:0] ITER_LAST = 6'(M - 2);
    localparam logic [4:0] CNT_LAST  = 5'(M - 1);
    localparam logic [M-1:0] MSB_MASK = {1'b1, {(M-1){1'b0}}};

    state_t       state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [M-1:0] out_inv_q;
    logic [M-1:0] a_q, r_q, acc_q;
    logic [5:0]   iter_q;
    logic [4:0]   cnt_q;
`ifdef GF_INV_ZERO_FLAG_EN
    logic         zero_q;
`endif

    logic [M-1:0] y_op;
    logic         y_bit;
    logic         last;
    logic [M-1:0] prod_d;

    // Squaring uses R as both operands; multiply uses R times the latched operand.
    always_comb begin
        y_op   = (state_q == MUL) ? a_q : r_q;
        y_bit  = |(y_op & (MSB_MASK >> cnt_q));
        last   = (cnt_q == CNT_LAST);
        prod_d = {acc_q[M-2:0], 1'b0}
               ^ (acc_q[M-1] ? POLY[M-1:0] : '0)
               ^ (y_bit ? r_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_inv_q   <= '0;
            a_q         <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            iter_q      <= '0;
            cnt_q       <= '0;
`ifdef GF_INV_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        a_q        <= in_a;
                        r_q        <= in_a;
                        acc_q      <= '0;
                        iter_q     <= 6'd1;
                        cnt_q      <= '0;
                        state_q    <= SQR;
`ifdef GF_INV_ZERO_FLAG_EN
                        zero_q     <= (in_a == '0);
`endif
                    end
                end
                SQR, MUL: begin
                    if (last) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        r_q   <= prod_d;
                        if (state_q == MUL) begin
                            iter_q  <= iter_q + 6'd1;
                            state_q <= SQR;
                        end else if (iter_q <= ITER_LAST) begin
                            state_q <= MUL;
                        end else begin
                            // Final squaring turns a^(2^(M-1)-1) into a^(2^M-2).
                            out_valid_q <= 1'b1;
                            out_inv_q   <= prod_d;
                            state_q     <= DONE;
                        end
                    end else begin
                        acc_q <= prod_d;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
`ifdef GF_INV_ZERO_FLAG_EN
                        zero_q      <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_inv     = out_inv_q;
    assign dbg_state_o = state_q;
`ifdef GF_INV_ZERO_FLAG_EN
    assign out_zero    = zero_q;
`endif

endmodule

// File: tb/tb_gf_inv_serial.sv
// Bench for gf_inv_serial (M=16): directed cases, backpressure, mid-run reset and random operands
// checked against a polynomial-long-division / exponentiation reference model.
module tb_gf_inv_serial;
    localparam int M = 16;
    localparam int LAT = (2*M-3)*M;
    localparam int N_RAND = 120;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] in_a = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   dbg_state;
    logic [M-1:0] out_inv;
`ifdef GF_INV_ZERO_FLAG_EN
    logic         out_zero;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [M-1:0] exp_q[$];

    gf_inv_serial #(.M(M), .POLY(17'h1002B)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state_o(dbg_state),
        .out_inv(out_inv)
`ifdef GF_INV_ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full polynomial product, then long division by the field polynomial.
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [31:0] p = '0;
        logic [31:0] poly = 32'h0001002B;
        for (int i = 0; i < M; i++)
            if (y[i]) p = p ^ ({16'b0, x} << i);
        for (int i = 2*M-1; i >= M; i--)
            if (p[i]) p = p ^ (poly << (i - M));
        return p[M-1:0];
    endfunction

    // Reference: a^(2^M-2) by square-and-multiply over the exponent bits.
    function automatic logic [M-1:0] ref_inv(input logic [M-1:0] a);
        logic [M-1:0] res = 16'h0001;
        logic [M-1:0] base = a;
        int e = (1 << M) - 2;
        while (e != 0) begin
            if (e & 1) res = ref_mul(res, base);
            base = ref_mul(base, base);
            e = e >> 1;
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [M-1:0] a);
        int guard = 0;
        while (!in_ready && guard < 1000) begin
            tick();
            guard++;
        end
        check("send_ready_timeout", 32'(guard < 1000), 32'd1);
        in_valid = 1'b1;
        in_a = a;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input logic [M-1:0] a, input int stall, input bit noise);
        int cyc = 0;
        logic [M-1:0] held;
        logic [M-1:0] exp;
        while (!out_valid && cyc < LAT + 100) begin
            if (noise) begin
                check("busy_in_ready", 32'(in_ready), 32'd0);
                in_valid = 1'($urandom_range(0, 1));
                in_a = 16'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("latency", 32'(cyc), 32'(LAT));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("inv", 32'(out_inv), 32'(exp));
        if (a != '0) check("a_times_inv", 32'(ref_mul(a, out_inv)), 32'd1);
`ifdef GF_INV_ZERO_FLAG_EN
        check("zero_flag", 32'(out_zero), 32'(a == '0));
`endif
        held = out_inv;
        for (int k = 0; k < stall; k++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = 16'($urandom);
            end
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_inv", 32'(out_inv), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ret_valid", 32'(out_valid), 32'd0);
        check("ret_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_one(input logic [M-1:0] a, input int stall, input bit noise);
        exp_q.push_back(ref_inv(a));
        send(a);
        collect(a, stall, noise);
    endtask

    initial begin
        logic [M-1:0] a;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inv", 32'(out_inv), 32'd0);
`ifdef GF_INV_ZERO_FLAG_EN
        check("rst_out_zero", 32'(out_zero), 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Known pair from the field definition, both directions.
        run_one(16'h0002, 0, 1'b0);
        check("known_inv_of_2", 32'(ref_inv(16'h0002)), 32'h8015);
        run_one(16'h8015, 0, 1'b0);
        run_one(16'h0000, 0, 1'b0);
        run_one(16'h0001, 0, 1'b0);
        run_one(16'hFFFF, 3, 1'b0);

        // Backpressure with input noise while busy.
        run_one(16'h1234, 50, 1'b1);

        // Reset in the middle of a computation.
        send(16'hBEEF);
        repeat (100) tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        repeat (LAT) begin
            tick();
            if (out_valid) check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        run_one(16'h0001, 0, 1'b0);

        for (int n = 0; n < N_RAND; n++) begin
            a = 16'($urandom_range(1, 65535));
            run_one(a, $urandom_range(0, 6), 1'b1);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
